// File: rtl/smj_pkg.sv
// Shared tile types and loader constants for the SMJ hand judge and its front end.
// Tiles are opaque 6-bit codes; the sentinel is the maximum code.
package smj_pkg;
  typedef logic [5:0] tile_t;
  localparam int HAND_SIZE = 5;
  localparam tile_t TILE_SENTINEL = 6'h3F;
  typedef enum logic {FILL, HOLD} ldr_state_t;
  typedef tile_t [HAND_SIZE-1:0] hand_t;
endpackage

// File: rtl/smj_sort_insert.sv
// Combinational stable insertion of one tile into the sorted, partly occupied slot array.
// Zero latency; no flow control of its own, the caller decides when to commit the result.
module smj_sort_insert
  import smj_pkg::*;
(
  input  hand_t      slot,
  input  logic [2:0] count,
  input  tile_t      tile,
  output hand_t      slot_nxt
);

  // le[i]: slot i is occupied and keeps its position (ties stay ahead of the new tile).
  // Occupied slots are sorted, so le is a run of ones from bit 0.
  logic [HAND_SIZE-1:0] le;

  always_comb begin
    for (int i = 0; i < HAND_SIZE; i++) begin
      le[i] = (3'(i) < count) && (slot[i] <= tile);
    end
    slot_nxt[0] = le[0] ? slot[0] : tile;
    for (int i = 1; i < HAND_SIZE; i++) begin
      slot_nxt[i] = le[i] ? slot[i] : (le[i-1] ? tile : slot[i-1]);
    end
  end

endmodule

// File: rtl/smj_hand_loader.sv
// Accepts one tile per cycle into a sorted 5-slot hand, then holds it for the judge until out_ready.
// Hand visible the edge the 5th tile lands; in_ready drops while a hand is held, no input buffering.
module smj_hand_loader
  import smj_pkg::*;
#(
  parameter int HAND_SIZE = 5,
  parameter int TILE_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [TILE_W-1:0] in_tile,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TILE_W-1:0] hand_n0,
  output logic [TILE_W-1:0] hand_n1,
  output logic [TILE_W-1:0] hand_n2,
  output logic [TILE_W-1:0] hand_n3,
  output logic [TILE_W-1:0] hand_n4,
  output logic              out_err
);

  ldr_state_t state_q, state_d;
  logic [2:0] count_q, count_d;
  hand_t      slot_q, slot_d, ins_slot;
  logic       err_q, err_d;

  smj_sort_insert u_sort_insert (
    .slot     (slot_q),
    .count    (count_q),
    .tile     (in_tile),
    .slot_nxt (ins_slot)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    slot_d  = slot_q;
    err_d   = err_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          slot_d  = ins_slot;
          count_d = count_q + 3'd1;
          if (count_q == 3'(HAND_SIZE - 1)) begin
            state_d = HOLD;
            // Sorted hand: all five equal exactly when the ends match.
            err_d   = (ins_slot[0] == ins_slot[HAND_SIZE-1]);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          count_d = 3'd0;
          slot_d  = {HAND_SIZE{TILE_SENTINEL}};
          err_d   = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      count_q <= 3'd0;
      slot_q  <= {HAND_SIZE{TILE_SENTINEL}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      slot_q  <= slot_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out_err   = err_q;
  assign hand_n0   = slot_q[0];
  assign hand_n1   = slot_q[1];
  assign hand_n2   = slot_q[2];
  assign hand_n3   = slot_q[3];
  assign hand_n4   = slot_q[4];

endmodule

// File: tb/tb_smj_hand_loader.sv
// Directed bench for smj_hand_loader: sorting, hold/back-pressure, error flag and async reset.
module tb_smj_hand_loader;
  import smj_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  in_valid;
  tile_t in_tile;
  logic  in_ready;
  logic  out_valid;
  logic  out_ready;
  tile_t hand_n0, hand_n1, hand_n2, hand_n3, hand_n4;
  logic  out_err;
  logic [29:0] hand_w;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [29:0] EMPTY = {5{6'h3F}};

  always #5 clk = ~clk;

  assign hand_w = {hand_n0, hand_n1, hand_n2, hand_n3, hand_n4};

  smj_hand_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_tile   (in_tile),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hand_n0   (hand_n0),
    .hand_n1   (hand_n1),
    .hand_n2   (hand_n2),
    .hand_n3   (hand_n3),
    .hand_n4   (hand_n4),
    .out_err   (out_err)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input tile_t t);
    in_valid = 1'b1;
    in_tile  = t;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_tile = 6'h00; out_ready = 1'b0;
    #12;
    n_vec++; if (hand_w !== EMPTY) begin n_err++; $display("FAIL reset_hand got %h want %h", hand_w, EMPTY); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL reset_out_err got %b want 0", out_err); end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_unsorted_fill();
    tile_t seq [5] = '{6'h12, 6'h05, 6'h21, 6'h05, 6'h30};
    logic [29:0] exp;
    for (int i = 0; i < 5; i++) begin
      feed(seq[i]);
      if (i == 1) begin
        exp = {6'h05, 6'h12, 6'h3F, 6'h3F, 6'h3F};
        n_vec++; if (hand_w !== exp) begin n_err++; $display("FAIL fill_partial got %h want %h", hand_w, exp); end
      end
    end
    exp = {6'h05, 6'h05, 6'h12, 6'h21, 6'h30};
    n_vec++; if (hand_w !== exp) begin n_err++; $display("FAIL fill_hand got %h want %h", hand_w, exp); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fill_out_valid got %b want 1", out_valid); end
    n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL fill_out_err got %b want 0", out_err); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
  endtask

  task automatic test_backpressure();
    logic [29:0] exp = {6'h05, 6'h05, 6'h12, 6'h21, 6'h30};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tile   = 6'h01;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_vec++; if (hand_w !== exp) begin n_err++; $display("FAIL bp_hand[%0d] got %h want %h", i, hand_w, exp); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, out_valid); end
    end
    in_valid = 1'b0;
    drain();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    n_vec++; if (hand_w !== EMPTY) begin n_err++; $display("FAIL bp_release_hand got %h want %h", hand_w, EMPTY); end
  endtask

  task automatic test_error();
    for (int i = 0; i < 5; i++) feed(6'h3F);
    n_vec++; if (hand_w !== EMPTY) begin n_err++; $display("FAIL err_hand got %h want %h", hand_w, EMPTY); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL err_out_valid got %b want 1", out_valid); end
    n_vec++; if (out_err !== 1'b1) begin n_err++; $display("FAIL err_flag got %b want 1", out_err); end
    drain();
    n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL err_clear got %b want 0", out_err); end
  endtask

  task automatic test_gaps();
    tile_t seq [5] = '{6'h30, 6'h20, 6'h10, 6'h08, 6'h01};
    logic [29:0] exp;
    for (int i = 0; i < 5; i++) begin
      feed(seq[i]);
      if (i == 3) begin
        exp = {6'h08, 6'h10, 6'h20, 6'h30, 6'h3F};
        n_vec++; if (hand_w !== exp) begin n_err++; $display("FAIL gap_partial got %h want %h", hand_w, exp); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL gap_early_valid got %b want 0", out_valid); end
      end
      in_tile = 6'h3E;
      cycle();
    end
    exp = {6'h01, 6'h08, 6'h10, 6'h20, 6'h30};
    n_vec++; if (hand_w !== exp) begin n_err++; $display("FAIL gap_hand got %h want %h", hand_w, exp); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL gap_out_valid got %b want 1", out_valid); end
    in_valid = 1'b1; in_tile = 6'h00;
    cycle(); cycle();
    in_valid = 1'b0;
    n_vec++; if (hand_w !== exp) begin n_err++; $display("FAIL gap_no_sixth got %h want %h", hand_w, exp); end
    drain();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL gap_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_reset_midfill();
    logic [29:0] exp;
    feed(6'h07); feed(6'h04); feed(6'h09);
    exp = {6'h04, 6'h07, 6'h09, 6'h3F, 6'h3F};
    n_vec++; if (hand_w !== exp) begin n_err++; $display("FAIL mid_partial got %h want %h", hand_w, exp); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (hand_w !== EMPTY) begin n_err++; $display("FAIL mid_async_hand got %h want %h", hand_w, EMPTY); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_async_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_out_valid got %b want 0", out_valid); end
    #1 rst_n = 1'b1;
    cycle();
    feed(6'h02); feed(6'h02); feed(6'h02); feed(6'h02);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_count_restart got %b want 0", out_valid); end
    feed(6'h03);
    exp = {6'h02, 6'h02, 6'h02, 6'h02, 6'h03};
    n_vec++; if (hand_w !== exp) begin n_err++; $display("FAIL mid_hand got %h want %h", hand_w, exp); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_out_valid got %b want 1", out_valid); end
    n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL mid_out_err got %b want 0", out_err); end
  endtask

  initial begin
    test_reset();
    test_unsorted_fill();
    test_backpressure();
    test_error();
    test_gaps();
    test_reset_midfill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
